// File: rtl/owmc_layer_controller.sv
// owmc_layer_controller
//   Weight memory controller for the PE weight-register bank. It streams a
//   layer's weights into weight RAM over a valid/ready interface. It then
//   serves register-load requests. Each request reads NUM_REGS consecutive
//   words, starting at a read offset that advances by itself and wraps to 0
//   at the end of the stored layer.
//
// Ports
//   OWMC_LAYER_CONTROLLER_Clk / _Reset         clock, synchronous active-high reset
//   _Start_Load_Weights, _Load_Count           begin a weight load of Load_Count words
//   _Wr_Valid, _Wr_Data, _Wr_Ready             weight stream (word taken on Valid&Ready)
//   _Start_Load_Regs                           begin one register load
//   _Offset_Clear                              reset read offset to 0 (IDLE/READY)
//   _Done_Ack                                  acknowledge Weights_Done / Regs_Done
//   _Ram_Addr, _Ram_We, _Ram_Oe, _Ram_Wdata    weight RAM control
//   _Ram_Rdata                                 RAM read data, one cycle after Oe
//   _Reg_We, _Reg_Sel, _Reg_Data               weight-register write port
//   _Weights_Done, _Regs_Done                  completion flags (held until ack)
//   _Error                                     one-cycle pulse on a rejected request
//   _Checksum                                  running sum of the current weight load
//
// Build option
//   OWMC_LAYER_CONTROLLER_CHECKSUM_EN : builds the checksum accumulator.
//   When it is undefined, Checksum is tied to 0.

module owmc_layer_controller #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned NUM_REGS = 9,
  parameter int unsigned SEL_W    = 4
) (
  input  logic              OWMC_LAYER_CONTROLLER_Clk,
  input  logic              OWMC_LAYER_CONTROLLER_Reset,
  input  logic              OWMC_LAYER_CONTROLLER_Start_Load_Weights,
  input  logic [ADDR_W:0]   OWMC_LAYER_CONTROLLER_Load_Count,
  input  logic              OWMC_LAYER_CONTROLLER_Wr_Valid,
  input  logic [DATA_W-1:0] OWMC_LAYER_CONTROLLER_Wr_Data,
  output logic              OWMC_LAYER_CONTROLLER_Wr_Ready,
  input  logic              OWMC_LAYER_CONTROLLER_Start_Load_Regs,
  input  logic              OWMC_LAYER_CONTROLLER_Offset_Clear,
  input  logic              OWMC_LAYER_CONTROLLER_Done_Ack,
  output logic [ADDR_W-1:0] OWMC_LAYER_CONTROLLER_Ram_Addr,
  output logic              OWMC_LAYER_CONTROLLER_Ram_We,
  output logic              OWMC_LAYER_CONTROLLER_Ram_Oe,
  output logic [DATA_W-1:0] OWMC_LAYER_CONTROLLER_Ram_Wdata,
  input  logic [DATA_W-1:0] OWMC_LAYER_CONTROLLER_Ram_Rdata,
  output logic              OWMC_LAYER_CONTROLLER_Reg_We,
  output logic [SEL_W-1:0]  OWMC_LAYER_CONTROLLER_Reg_Sel,
  output logic [DATA_W-1:0] OWMC_LAYER_CONTROLLER_Reg_Data,
  output logic              OWMC_LAYER_CONTROLLER_Weights_Done,
  output logic              OWMC_LAYER_CONTROLLER_Regs_Done,
  output logic              OWMC_LAYER_CONTROLLER_Error,
  output logic [DATA_W-1:0] OWMC_LAYER_CONTROLLER_Checksum
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_WAIT_W, S_LOAD_R, S_DRAIN_R, S_WAIT_R, S_READY
  } state_t;

  localparam logic [ADDR_W:0]  MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  NREGS   = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0]  ONE     = (ADDR_W+1)'(1);
  localparam logic [SEL_W-1:0] LAST_K  = SEL_W'(NUM_REGS - 1);
  localparam logic [SEL_W-1:0] K_ONE   = SEL_W'(1);

  state_t            r_state;
  // The counters are one bit wider than the RAM address, so that a full
  // 2^ADDR_W layer and offset+NUM_REGS can both be represented.
  logic [ADDR_W:0]   r_addr;
  logic [ADDR_W:0]   r_offset;
  logic [ADDR_W:0]   r_count;
  logic [SEL_W-1:0]  r_k;
  logic              r_reg_we;
  logic [SEL_W-1:0]  r_reg_sel;
  logic              r_error;

  logic              w_cmd_state;
  logic              w_ram_we;
  logic              w_ram_oe;
  logic              w_sw_ok;
  logic              w_sr_ok;
  logic [ADDR_W:0]   w_rd_end;
  logic [ADDR_W:0]   w_addr_nx;

  assign w_cmd_state = (r_state == S_IDLE) || (r_state == S_READY);
  assign w_ram_we    = (r_state == S_LOAD_W) && OWMC_LAYER_CONTROLLER_Wr_Valid;
  assign w_ram_oe    = (r_state == S_LOAD_R);
  assign w_rd_end    = r_offset + NREGS;
  assign w_addr_nx   = r_addr + ONE;
  assign w_sw_ok     = OWMC_LAYER_CONTROLLER_Load_Count <= MAX_CNT;
  assign w_sr_ok     = w_rd_end <= r_count;

  always_ff @(posedge OWMC_LAYER_CONTROLLER_Clk) begin
    if (OWMC_LAYER_CONTROLLER_Reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_offset  <= '0;
      r_count   <= '0;
      r_k       <= '0;
      r_reg_we  <= 1'b0;
      r_reg_sel <= '0;
      r_error   <= 1'b0;
    end else begin
      r_error   <= 1'b0;
      r_reg_we  <= 1'b0;
      r_reg_sel <= '0;
      case (r_state)
        S_IDLE, S_READY: begin
          if (OWMC_LAYER_CONTROLLER_Start_Load_Weights) begin
            if (w_sw_ok) begin
              r_count  <= OWMC_LAYER_CONTROLLER_Load_Count;
              r_addr   <= '0;
              r_offset <= '0;
              r_state  <= (OWMC_LAYER_CONTROLLER_Load_Count == '0) ? S_WAIT_W : S_LOAD_W;
            end else begin
              r_error  <= 1'b1;
            end
          end else if (OWMC_LAYER_CONTROLLER_Start_Load_Regs) begin
            if (w_sr_ok) begin
              r_addr   <= r_offset;
              r_k      <= '0;
              r_state  <= S_LOAD_R;
            end else begin
              r_error  <= 1'b1;
            end
          end else if (OWMC_LAYER_CONTROLLER_Offset_Clear) begin
            r_offset <= '0;
          end
        end
        S_LOAD_W: begin
          if (OWMC_LAYER_CONTROLLER_Wr_Valid) begin
            r_addr <= w_addr_nx;
            if (w_addr_nx == r_count) r_state <= S_WAIT_W;
          end
        end
        S_WAIT_W: begin
          if (OWMC_LAYER_CONTROLLER_Done_Ack) r_state <= S_READY;
        end
        S_LOAD_R: begin
          // The register strobe for issue k lines up with the RAM read latency.
          r_reg_we  <= 1'b1;
          r_reg_sel <= r_k;
          r_addr    <= w_addr_nx;
          r_k       <= r_k + K_ONE;
          if (r_k == LAST_K) r_state <= S_DRAIN_R;
        end
        S_DRAIN_R: begin
          r_offset <= (w_rd_end == r_count) ? '0 : w_rd_end;
          r_state  <= S_WAIT_R;
        end
        S_WAIT_R: begin
          if (OWMC_LAYER_CONTROLLER_Done_Ack) r_state <= S_READY;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef OWMC_LAYER_CONTROLLER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge OWMC_LAYER_CONTROLLER_Clk) begin
    if (OWMC_LAYER_CONTROLLER_Reset) begin
      r_csum <= '0;
    end else if (w_cmd_state && OWMC_LAYER_CONTROLLER_Start_Load_Weights && w_sw_ok) begin
      r_csum <= '0;
    end else if (w_ram_we) begin
      r_csum <= r_csum + OWMC_LAYER_CONTROLLER_Wr_Data;
    end
  end

  assign OWMC_LAYER_CONTROLLER_Checksum = r_csum;
`else
  assign OWMC_LAYER_CONTROLLER_Checksum = '0;
`endif

  assign OWMC_LAYER_CONTROLLER_Wr_Ready     = (r_state == S_LOAD_W);
  assign OWMC_LAYER_CONTROLLER_Ram_We       = w_ram_we;
  assign OWMC_LAYER_CONTROLLER_Ram_Oe       = w_ram_oe;
  assign OWMC_LAYER_CONTROLLER_Ram_Addr     = (w_ram_we || w_ram_oe) ? r_addr[ADDR_W-1:0] : '0;
  assign OWMC_LAYER_CONTROLLER_Ram_Wdata    = w_ram_we ? OWMC_LAYER_CONTROLLER_Wr_Data : '0;
  assign OWMC_LAYER_CONTROLLER_Reg_We       = r_reg_we;
  assign OWMC_LAYER_CONTROLLER_Reg_Sel      = r_reg_sel;
  assign OWMC_LAYER_CONTROLLER_Reg_Data     = r_reg_we ? OWMC_LAYER_CONTROLLER_Ram_Rdata : '0;
  assign OWMC_LAYER_CONTROLLER_Weights_Done = (r_state == S_WAIT_W);
  assign OWMC_LAYER_CONTROLLER_Regs_Done    = (r_state == S_WAIT_R);
  assign OWMC_LAYER_CONTROLLER_Error        = r_error;

endmodule

// File: tb/tb_owmc_layer_controller.sv
module tb_owmc_layer_controller;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned NUM_REGS = 9;
  localparam int unsigned SEL_W    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_w = 1'b0;
  logic [ADDR_W:0]   load_count = '0;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = 8'h5A;
  logic              wr_ready;
  logic              start_r = 1'b0;
  logic              off_clr = 1'b0;
  logic              done_ack = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_oe;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              reg_we;
  logic [SEL_W-1:0]  reg_sel;
  logic [DATA_W-1:0] reg_data;
  logic              w_done;
  logic              r_done;
  logic              err;
  logic [DATA_W-1:0] csum;

  owmc_layer_controller #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)
  ) dut (
    .OWMC_LAYER_CONTROLLER_Clk                (clk),
    .OWMC_LAYER_CONTROLLER_Reset              (rst),
    .OWMC_LAYER_CONTROLLER_Start_Load_Weights (start_w),
    .OWMC_LAYER_CONTROLLER_Load_Count         (load_count),
    .OWMC_LAYER_CONTROLLER_Wr_Valid           (wr_valid),
    .OWMC_LAYER_CONTROLLER_Wr_Data            (wr_data),
    .OWMC_LAYER_CONTROLLER_Wr_Ready           (wr_ready),
    .OWMC_LAYER_CONTROLLER_Start_Load_Regs    (start_r),
    .OWMC_LAYER_CONTROLLER_Offset_Clear       (off_clr),
    .OWMC_LAYER_CONTROLLER_Done_Ack           (done_ack),
    .OWMC_LAYER_CONTROLLER_Ram_Addr           (ram_addr),
    .OWMC_LAYER_CONTROLLER_Ram_We             (ram_we),
    .OWMC_LAYER_CONTROLLER_Ram_Oe             (ram_oe),
    .OWMC_LAYER_CONTROLLER_Ram_Wdata          (ram_wdata),
    .OWMC_LAYER_CONTROLLER_Ram_Rdata          (ram_rdata),
    .OWMC_LAYER_CONTROLLER_Reg_We             (reg_we),
    .OWMC_LAYER_CONTROLLER_Reg_Sel            (reg_sel),
    .OWMC_LAYER_CONTROLLER_Reg_Data           (reg_data),
    .OWMC_LAYER_CONTROLLER_Weights_Done       (w_done),
    .OWMC_LAYER_CONTROLLER_Regs_Done          (r_done),
    .OWMC_LAYER_CONTROLLER_Error              (err),
    .OWMC_LAYER_CONTROLLER_Checksum           (csum)
  );

  always #5 clk = ~clk;

  // Weight RAM with one cycle of read latency.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    if (ram_oe) ram_rdata <= ram[ram_addr];
  end

  typedef struct {
    int unsigned a;
    int unsigned d;
  } ev_t;

  ev_t q_wr[$];
  ev_t q_rd[$];
  ev_t q_reg[$];
  int  exp_err = 0;
  int  exp_mem [0:(1<<ADDR_W)-1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each presented output event pops its expected record.
  always @(negedge clk) begin
    ev_t e;
    if (ram_we && ram_oe) chk("we_oe_exclusive", 1, 0);
    if (ram_we) begin
      if (q_wr.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        e = q_wr.pop_front();
        chk("wr_addr", 64'(ram_addr), 64'(e.a));
        chk("wr_data", 64'(ram_wdata), 64'(e.d));
      end
    end
    if (ram_oe) begin
      if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        e = q_rd.pop_front();
        chk("rd_addr", 64'(ram_addr), 64'(e.a));
      end
    end
    if (reg_we) begin
      if (q_reg.size() == 0) chk("reg_unexpected", 1, 0);
      else begin
        e = q_reg.pop_front();
        chk("reg_sel", 64'(reg_sel), 64'(e.a));
        chk("reg_data", 64'(reg_data), 64'(e.d));
      end
    end
    if (err) begin
      if (exp_err == 0) chk("err_unexpected", 1, 0);
      else begin
        exp_err--;
        chk("err_pulse", 64'(err), 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_flag(input bit regs, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = regs ? r_done : w_done;
    end
    chk(name, 64'(seen), 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 64'({wr_ready, ram_addr, ram_we, ram_oe, ram_wdata, reg_we, reg_sel,
                   reg_data, w_done, r_done, err, csum}), 0);
  endtask

  task automatic ack(input bit regs, input string name);
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    @(negedge clk);
    chk(name, 64'(regs ? r_done : w_done), 0);
    step();
  endtask

  // Stream count words base, base+1, ... with Valid low on every other cycle.
  task automatic load_w(input int cnt, input int base, input string name);
    int sum = 0;
    start_w = 1'b1;
    load_count = (ADDR_W+1)'(cnt);
    step();
    start_w = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      wr_valid = 1'b0;
      wr_data  = 8'hEE;
      step();
      wr_data  = DATA_W'(base + i);
      wr_valid = 1'b1;
      q_wr.push_back('{a: i, d: (base + i) & 'hFF});
      exp_mem[i] = (base + i) & 'hFF;
      sum += base + i;
      step();
    end
    wr_valid = 1'b0;
    wr_data  = 8'h5A;
    wait_flag(1'b0, {name, "_wdone"});
`ifdef OWMC_LAYER_CONTROLLER_CHECKSUM_EN
    chk({name, "_csum"}, 64'(csum), 64'(sum & 'hFF));
`endif
    ack(1'b0, {name, "_wdone_clr"});
  endtask

  task automatic load_r(input int off, input string name);
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      q_rd.push_back('{a: off + k, d: 0});
      q_reg.push_back('{a: k, d: exp_mem[off + k]});
    end
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    wait_flag(1'b1, {name, "_rdone"});
    ack(1'b1, {name, "_rdone_clr"});
  endtask

  task automatic req_error(input bit weights, input int cnt, input string name);
    exp_err++;
    start_w = weights;
    start_r = !weights;
    load_count = (ADDR_W+1)'(cnt);
    step();
    start_w = 1'b0;
    start_r = 1'b0;
    step();
    step();
    @(negedge clk);
    chk({name, "_flags"}, 64'({w_done, r_done, err}), 0);
    chk({name, "_consumed"}, 64'(exp_err), 0);
    step();
  endtask

  initial begin
    step();
    step();
    @(negedge clk);
    chk_all_zero("reset_outputs");
    step();
    rst = 1'b0;
    step();

    // 18 words 0x01..0x12, checksum 0xAB.
    load_w(18, 1, "load18");
    load_r(0, "regs_a");
    load_r(9, "regs_b");
    load_r(0, "regs_wrap");

    // 10 words 0xA0..0xA9, checksum 0x6D; the second request overruns.
    load_w(10, 'hA0, "load10");
    load_r(0, "regs10");
    req_error(1'b0, 0, "overrun");

    // Offset is 9 here; clear it, then reset on the 4th LOAD_R cycle.
    off_clr = 1'b1;
    step();
    off_clr = 1'b0;
    for (int k = 0; k < 4; k++) q_rd.push_back('{a: k, d: 0});
    for (int k = 0; k < 3; k++) q_reg.push_back('{a: k, d: exp_mem[k]});
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_mid_load");
    step();
    req_error(1'b0, 0, "regs_after_reset");

    // Weights win over regs; zero-length load goes straight to WAIT_W.
    load_w(9, 'h50, "load9");
    start_w = 1'b1;
    start_r = 1'b1;
    load_count = '0;
    step();
    start_w = 1'b0;
    start_r = 1'b0;
    @(negedge clk);
    chk("zero_load_wdone", 64'({w_done, r_done, ram_oe, wr_ready}), 64'(4'b1000));
`ifdef OWMC_LAYER_CONTROLLER_CHECKSUM_EN
    chk("zero_load_csum", 64'(csum), 0);
`endif
    step();
    ack(1'b0, "zero_load_clr");
    req_error(1'b0, 0, "regs_count0");
    req_error(1'b1, (1 << ADDR_W) + 1, "count_too_big");

    step();
    step();
    chk("q_wr_empty", 64'(q_wr.size()), 0);
    chk("q_rd_empty", 64'(q_rd.size()), 0);
    chk("q_reg_empty", 64'(q_reg.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
